// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour width and the clear FSM encoding.
package vga_pkg;
  localparam int VGA_H_ACTIVE = 1024;
  localparam int VGA_V_ACTIVE = 768;
  localparam int VGA_H_LAST   = 1328;
  localparam int VGA_V_LAST   = 806;
  localparam int COLOR_W      = 12;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clrState_t;
endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old word.
module fb_ram_dp #(
  parameter int DEPTH  = 49152,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/vga_framebuffer.sv
// Scaled frame-buffer pixel source for the 1024x768 VGA driver, with a
// valid/ready write port and a whole-buffer clear FSM.
module vga_framebuffer
  import vga_pkg::*;
#(
  parameter int FB_W        = 256,
  parameter int FB_H        = 192,
  parameter int SCALE_SHIFT = 2,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int H_LAST      = VGA_H_LAST,
  parameter int V_LAST      = VGA_V_LAST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         posX,
  input  logic [10:0]         posY,
  output logic [COLOR_W-1:0]  pixel_out,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [7:0]          wr_x,
  input  logic [7:0]          wr_y,
  input  logic [COLOR_W-1:0]  wr_color,
  input  logic                clear_req,
  input  logic [COLOR_W-1:0]  clear_color,
  output logic                clear_busy,
  output logic                clear_done
);
  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [12:0]         lxSum, lx, colIdx;
  logic [11:0]         row, rowIdx;
  logic                lookActive, rowInFb;
  logic [ADDR_W-1:0]   rdAddr;
  logic [COLOR_W-1:0]  rdData;
  logic                act1;

  logic                ramWe, wrInFb;
  logic [ADDR_W-1:0]   ramWrAddr;
  logic [COLOR_W-1:0]  ramWrData;

  clrState_t           state;
  logic [ADDR_W-1:0]   clrCnt;
  logic [COLOR_W-1:0]  clrColor;

  // Two pixels ahead of the driver, following its own wrap rules.
  always_comb begin
    lxSum = {1'b0, posX} + 13'd2;
    lx    = lxSum;
    row   = {1'b0, posY};
    if (lxSum > 13'(H_LAST)) begin
      lx  = lxSum - 13'(H_LAST + 1);
      row = {1'b0, posY} + 12'd1;
      if (row > 12'(V_LAST)) row = '0;
    end
    rowIdx     = row >> SCALE_SHIFT;
    colIdx     = lx >> SCALE_SHIFT;
    lookActive = (lx < 13'(H_ACTIVE)) && (row < 12'(V_ACTIVE));
    rowInFb    = 32'(rowIdx) < FB_H;
    rdAddr     = (lookActive && rowInFb)
               ? ADDR_W'(32'(rowIdx) * 32'(FB_W) + 32'(colIdx)) : '0;
  end

  // The RAM's synchronous read register acts as the stage-1 address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act1      <= 1'b0;
      pixel_out <= '0;
    end else begin
      act1      <= lookActive && rowInFb;
      pixel_out <= act1 ? rdData : '0;
    end
  end

  assign wr_ready = (state == ST_IDLE) && !clear_req;
  assign wrInFb   = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);

  always_comb begin
    if (state == ST_CLEAR) begin
      ramWe     = 1'b1;
      ramWrAddr = clrCnt;
      ramWrData = clrColor;
    end else begin
      ramWe     = wr_valid && wr_ready && wrInFb;
      ramWrAddr = ADDR_W'(32'(wr_y) * 32'(FB_W) + 32'(wr_x));
      ramWrData = wr_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clrCnt     <= '0;
      clrColor   <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state      <= ST_CLEAR;
            clrColor   <= clear_color;
            clrCnt     <= '0;
            clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clrCnt <= clrCnt + 1'b1;
          if (clrCnt == ADDR_W'(DEPTH - 1)) begin
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fb_ram_dp #(
    .DEPTH (DEPTH),
    .WIDTH (COLOR_W)
  ) u_ram (
    .clk    (clk),
    .we     (ramWe),
    .wrAddr (ramWrAddr),
    .wrData (ramWrData),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );
endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed plus randomized bench for vga_framebuffer against a screen-level model.
module tb_vga_framebuffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] posX;
  logic [10:0] posY;
  logic [11:0] pixel_out;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [11:0] wr_color;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_busy;
  logic        clear_done;

  int nCmp = 0;
  int nBad = 0;

  logic [11:0] fb [0:191][0:255];
  logic [11:0] expStage, expOut;
  bit          chkPix, scan, mBusy;

  always #5 clk = ~clk;

  vga_framebuffer dut (
    .clk         (clk),
    .rst         (rst),
    .posX        (posX),
    .posY        (posY),
    .pixel_out   (pixel_out),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  function automatic void advance(inout int x, inout int y);
    if (x == 1328) begin
      x = 0;
      y = (y == 806) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endfunction

  function automatic logic [11:0] screenPix(input int x, input int y);
    if (x < 1024 && y < 768) return fb[y / 4][x / 4];
    return 12'h000;
  endfunction

  function automatic logic [11:0] lookPix(input int x, input int y);
    int a = x;
    int b = y;
    advance(a, b);
    advance(a, b);
    return screenPix(a, b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int x;
    int y;
    @(posedge clk);
    expOut   = expStage;
    expStage = lookPix(int'(posX), int'(posY));
    if (wr_valid && !clear_req && !mBusy && wr_y < 8'd192) fb[wr_y][wr_x] = wr_color;
    #1;
    if (scan) begin
      x = int'(posX);
      y = int'(posY);
      advance(x, y);
      posX = 12'(x);
      posY = 11'(y);
    end
    @(negedge clk);
    if (chkPix) check("pixel", 32'(pixel_out), 32'(expOut));
  endtask

  task automatic seg(input int x, input int y, input int n);
    posX = 12'(x);
    posY = 11'(y);
    scan = 1'b1;
    repeat (n) tick();
    scan = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input logic [11:0] c);
    wr_valid = 1'b1;
    wr_x     = 8'(x);
    wr_y     = 8'(y);
    wr_color = c;
    #1;
    check("wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int busyCnt;
    int earlyDone;
    rst = 1'b0; posX = '0; posY = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_req = 1'b0; clear_color = '0;
    chkPix = 1'b0; scan = 1'b0; mBusy = 1'b0;
    expStage = '0; expOut = '0;

    repeat (3) @(negedge clk);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(wr_ready), 32'd1);

    // Full clear, colliding with a write in the request cycle.
    @(negedge clk);
    clear_req = 1'b1; clear_color = 12'h123;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd5; wr_color = 12'hABC;
    mBusy = 1'b1;
    #1;
    check("ready_vs_clear", 32'(wr_ready), 32'd0);
    tick();
    clear_req = 1'b0; wr_valid = 1'b0;
    busyCnt = 0; earlyDone = 0;
    for (int i = 0; i < 60000; i++) begin
      if (clear_busy !== 1'b1) break;
      busyCnt++;
      check("ready_in_clear", 32'(wr_ready), 32'd0);
      if (clear_done) earlyDone++;
      clear_req   = (busyCnt == 100);
      clear_color = 12'h777;
      tick();
    end
    clear_req = 1'b0;
    check("clear_len", 32'(busyCnt), 32'd49152);
    check("clear_done", 32'(clear_done), 32'd1);
    check("early_done", 32'(earlyDone), 32'd0);
    tick();
    check("done_pulse", 32'(clear_done), 32'd0);
    check("busy_after", 32'(clear_busy), 32'd0);
    check("ready_after", 32'(wr_ready), 32'd1);
    mBusy = 1'b0;
    for (int y = 0; y < 192; y++)
      for (int x = 0; x < 256; x++) fb[y][x] = 12'h123;
    repeat (2) tick();
    chkPix = 1'b1;

    for (int i = 0; i < 15; i++)
      seg($urandom_range(0, 1328), $urandom_range(0, 806), 30);

    // Single write and its 4x4 footprint with neighbours.
    wr(3, 2, 12'hF00);
    for (int y = 7; y <= 12; y++) seg(8, y, 12);

    // Row-wrap lookahead, right-edge word and horizontal blanking.
    wr(0, 1, 12'h0F0);
    wr(255, 0, 12'h00F);
    seg(1016, 3, 330);

    // Frame wrap and vertical blanking.
    seg(1320, 806, 20);
    seg(0, 770, 30);
    seg(1000, 768, 60);

    // Out-of-range row handshakes without touching the buffer.
    wr(7, 200, 12'hFFF);
    seg(20, 0, 40);

    // Read and write of the same word in the same cycle.
    posX = 12'd38; posY = 11'd40;
    repeat (2) tick();
    wr(10, 10, 12'hABC);
    repeat (3) tick();

    // Random writes with the driver running concurrently.
    posX = 12'($urandom_range(0, 1328));
    posY = 11'($urandom_range(0, 806));
    scan = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else wr($urandom_range(0, 255), $urandom_range(0, 199), 12'($urandom));
    end
    scan = 1'b0;
    for (int i = 0; i < 25; i++)
      seg($urandom_range(0, 1328), $urandom_range(0, 806), 40);

    // Reset in the middle of a clear.
    chkPix = 1'b0;
    clear_req = 1'b1; clear_color = 12'h456; mBusy = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (1000) tick();
    check("busy_mid", 32'(clear_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_pixel", 32'(pixel_out), 32'd0);
    check("midrst_busy", 32'(clear_busy), 32'd0);
    check("midrst_done", 32'(clear_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(wr_ready), 32'd1);
    mBusy = 1'b0;
    for (int a = 0; a < 1000; a++) fb[a / 256][a % 256] = 12'h456;
    expStage = '0; expOut = '0;
    chkPix = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_done", 32'(clear_done), 32'd0);
    end
    seg(900, 14, 60);
    seg(0, 0, 40);
    check("idle_ready", 32'(wr_ready), 32'd1);
    check("idle_busy", 32'(clear_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
